dcache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache answering the pipeline's data-side requests (`dmemREN`/`dmemWEN`/`dmemaddr`/`dmemstore` in, `dhit`/`dmemload` out) and issuing word transfers to the memory controller (`dREN`/`dWEN`/`daddr`/`dstore` out, `dwait`/`dload` in). It sits between the datapath and memory control on the data port only. On datapath halt it writes back every dirty block, then raises `flushed`.

---
 rtl/dcache_pkg.sv | 38 +++
 rtl/dcache_if.sv | 29 ++
 rtl/dcache.sv | 166 ++++++++++++++++
 tb/tb_dcache.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared data-cache types: address split, frame layout and FSM state encoding.
// The COUNT state exists only when DCACHE_HITCOUNT_EN is defined.
package dcache_pkg;

    localparam int DCACHE_SETS = 8;
    localparam int DC_IDX_W    = $clog2(DCACHE_SETS);
    localparam int DC_TAG_W    = 29 - DC_IDX_W;

    typedef struct packed {
        logic [DC_TAG_W-1:0] tag;
        logic [DC_IDX_W-1:0] idx;
        logic                blkoff;
        logic [1:0]          bytoff;
    } dcachef_t;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [DC_TAG_W-1:0] tag;
        logic [1:0][31:0]    data;
    } dcache_frame_t;

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        FETCH0,
        FETCH1,
        FLUSH_CHK,
        FLUSH_WB0,
        FLUSH_WB1,
`ifdef DCACHE_HITCOUNT_EN
        COUNT,
`endif
        DONE
    } dcache_state_t;

endpackage

// File: rtl/dcache_if.sv
// Data-cache port bundle: datapath request/response side plus the word-wide
// memory-controller side. The cache takes the slave view.
interface dcache_if;
    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    modport slave (
        input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport master (
        output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped write-back/write-allocate data cache with halt-time flush.
// Defining DCACHE_HITCOUNT_EN adds a hit counter written to CNT_ADDR after the flush.
module dcache
    import dcache_pkg::*;
#(
    parameter int          SETS     = DCACHE_SETS,
    parameter logic [31:0] CNT_ADDR = 32'h0000_3100
) (
    input  logic    CLK,
    input  logic    nRST,
    dcache_if.slave dcif
);

    dcache_state_t       state;
    logic [DC_IDX_W-1:0] ptr;
    logic                valid_q [SETS];
    logic                dirty_q [SETS];
    logic [DC_TAG_W-1:0] tag_q   [SETS];
    logic [1:0][31:0]    data_q  [SETS];
`ifdef DCACHE_HITCOUNT_EN
    logic [31:0]         hitcnt;
`endif

    dcachef_t      ra;
    dcache_frame_t cur;
    dcache_frame_t fl;
    logic          req;
    logic          hit;
    logic [1:0]    unused_bytoff;

    assign ra            = dcachef_t'(dcif.dmemaddr);
    assign unused_bytoff = ra.bytoff;
    assign cur = {valid_q[ra.idx], dirty_q[ra.idx], tag_q[ra.idx], data_q[ra.idx]};
    assign fl  = {valid_q[ptr], dirty_q[ptr], tag_q[ptr], data_q[ptr]};
    assign req = dcif.dmemREN | dcif.dmemWEN;

    // A pending halt blocks new hits so the flush sees a quiescent cache.
    assign hit = (state == IDLE) && !dcif.halt && req && cur.valid && (cur.tag == ra.tag);

    always_comb begin
        dcif.dhit     = hit;
        dcif.dmemload = (hit && dcif.dmemREN) ? cur.data[ra.blkoff] : '0;
        dcif.flushed  = (state == DONE);
        dcif.dREN     = 1'b0;
        dcif.dWEN     = 1'b0;
        dcif.daddr    = '0;
        dcif.dstore   = '0;
        case (state)
            WB0: begin
                dcif.dWEN   = 1'b1;
                dcif.daddr  = {cur.tag, ra.idx, 1'b0, 2'b00};
                dcif.dstore = cur.data[0];
            end
            WB1: begin
                dcif.dWEN   = 1'b1;
                dcif.daddr  = {cur.tag, ra.idx, 1'b1, 2'b00};
                dcif.dstore = cur.data[1];
            end
            FETCH0: begin
                dcif.dREN  = 1'b1;
                dcif.daddr = {ra.tag, ra.idx, 1'b0, 2'b00};
            end
            FETCH1: begin
                dcif.dREN  = 1'b1;
                dcif.daddr = {ra.tag, ra.idx, 1'b1, 2'b00};
            end
            FLUSH_WB0: begin
                dcif.dWEN   = 1'b1;
                dcif.daddr  = {fl.tag, ptr, 1'b0, 2'b00};
                dcif.dstore = fl.data[0];
            end
            FLUSH_WB1: begin
                dcif.dWEN   = 1'b1;
                dcif.daddr  = {fl.tag, ptr, 1'b1, 2'b00};
                dcif.dstore = fl.data[1];
            end
`ifdef DCACHE_HITCOUNT_EN
            COUNT: begin
                dcif.dWEN   = 1'b1;
                dcif.daddr  = CNT_ADDR;
                dcif.dstore = hitcnt;
            end
`endif
            default: ;
        endcase
    end

    // Block contents and tags carry no reset; validity lives in valid_q.
    always_ff @(posedge CLK) begin
        if (hit && dcif.dmemWEN)
            data_q[ra.idx][ra.blkoff] <= dcif.dmemstore;
        if (!dcif.dwait && state == FETCH0)
            data_q[ra.idx][0] <= dcif.dload;
        if (!dcif.dwait && state == FETCH1) begin
            data_q[ra.idx][1] <= dcif.dload;
            tag_q[ra.idx]     <= ra.tag;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            ptr   <= '0;
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
`ifdef DCACHE_HITCOUNT_EN
            hitcnt <= '0;
`endif
        end else begin
`ifdef DCACHE_HITCOUNT_EN
            if (hit)
                hitcnt <= hitcnt + 32'd1;
`endif
            case (state)
                IDLE: begin
                    if (dcif.halt) begin
                        state <= FLUSH_CHK;
                        ptr   <= '0;
                    end else if (hit) begin
                        if (dcif.dmemWEN)
                            dirty_q[ra.idx] <= 1'b1;
                    end else if (req) begin
                        state <= (cur.valid && cur.dirty) ? WB0 : FETCH0;
                    end
                end
                WB0:    if (!dcif.dwait) state <= WB1;
                WB1:    if (!dcif.dwait) state <= FETCH0;
                FETCH0: if (!dcif.dwait) state <= FETCH1;
                FETCH1: begin
                    if (!dcif.dwait) begin
                        valid_q[ra.idx] <= 1'b1;
                        dirty_q[ra.idx] <= 1'b0;
                        state           <= IDLE;
                    end
                end
                FLUSH_CHK: begin
                    if (fl.valid && fl.dirty)
                        state <= FLUSH_WB0;
                    else if (ptr == DC_IDX_W'(SETS - 1))
`ifdef DCACHE_HITCOUNT_EN
                        state <= COUNT;
`else
                        state <= DONE;
`endif
                    else
                        ptr <= ptr + 1'b1;
                end
                FLUSH_WB0: if (!dcif.dwait) state <= FLUSH_WB1;
                FLUSH_WB1: begin
                    if (!dcif.dwait) begin
                        dirty_q[ptr] <= 1'b0;
                        state        <= FLUSH_CHK;
                    end
                end
`ifdef DCACHE_HITCOUNT_EN
                COUNT: if (!dcif.dwait) state <= DONE;
`endif
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: directed requests push expected loads and
// memory transfers; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_dcache;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    dcache_if dcif();

    dcache #(.SETS(8), .CNT_ADDR(32'h0000_3100)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .dcif (dcif)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rd  = 0;
    int          n_wr  = 0;
    int          wait_cyc = 0;
    logic [31:0] exp_load [$];
    logic [31:0] exp_rd   [$];
    wr_t         exp_wr   [$];
    logic [31:0] mem [logic [31:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    // Memory responder: each transfer waits wait_cyc cycles, then completes.
    initial begin
        int wcnt;
        wcnt = 0;
        dcif.dwait = 1'b1;
        dcif.dload = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (nRST && (dcif.dREN || dcif.dWEN)) begin
                if (wcnt < wait_cyc) begin
                    dcif.dwait = 1'b1;
                    wcnt++;
                end else begin
                    dcif.dwait = 1'b0;
                    wcnt = 0;
                    if (dcif.dREN)
                        dcif.dload = mem.exists(dcif.daddr) ? mem[dcif.daddr] : 32'hBAD0_0000;
                    else
                        mem[dcif.daddr] = dcif.dstore;
                end
            end else begin
                dcif.dwait = 1'b1;
                wcnt = 0;
            end
        end
    end

    logic        hold_v = 1'b0;
    logic [1:0]  hold_ctl;
    logic [31:0] hold_addr;
    logic [31:0] hold_data;

    always @(negedge nRST) hold_v = 1'b0;

    always @(negedge CLK) begin
        if (nRST) begin
            if (dcif.dhit && dcif.dmemREN && !dcif.dmemWEN) begin
                if (exp_load.size() == 0) unexpected("load_data", dcif.dmemload);
                else check("load_data", dcif.dmemload, exp_load.pop_front());
            end
            if (dcif.dREN && !dcif.dwait) begin
                n_rd++;
                if (exp_rd.size() == 0) unexpected("rd_addr", dcif.daddr);
                else check("rd_addr", dcif.daddr, exp_rd.pop_front());
            end
            if (dcif.dWEN && !dcif.dwait) begin
                n_wr++;
                if (exp_wr.size() == 0) unexpected("wr_addr", dcif.daddr);
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", dcif.daddr, w.a);
                    check("wr_data", dcif.dstore, w.d);
                end
            end
            if (dcif.dREN || dcif.dWEN)
                check("ren_wen_excl", dcif.dREN & dcif.dWEN, 0);
            if (hold_v) begin
                check("hold_ctl", {dcif.dREN, dcif.dWEN}, hold_ctl);
                check("hold_addr", dcif.daddr, hold_addr);
                check("hold_data", dcif.dstore, hold_data);
            end
        end
        hold_v    = nRST && (dcif.dREN || dcif.dWEN) && dcif.dwait;
        hold_ctl  = {dcif.dREN, dcif.dWEN};
        hold_addr = dcif.daddr;
        hold_data = dcif.dstore;
    end

    task automatic req(input logic ren, input logic wen, input logic [31:0] a,
                       input logic [31:0] d, output int ncyc);
        logic seen;
        @(posedge CLK);
        #2;
        dcif.dmemREN   = ren;
        dcif.dmemWEN   = wen;
        dcif.dmemaddr  = a;
        dcif.dmemstore = d;
        ncyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge CLK);
            ncyc++;
            seen = dcif.dhit;
        end
        if (!seen) unexpected("req_timeout", a);
        @(posedge CLK);
        #2;
        dcif.dmemREN = 1'b0;
        dcif.dmemWEN = 1'b0;
    endtask

    initial begin
        int   nc;
        int   r0;
        int   w0;
        logic found;

        dcif.halt      = 1'b0;
        dcif.dmemREN   = 1'b0;
        dcif.dmemWEN   = 1'b0;
        dcif.dmemaddr  = '0;
        dcif.dmemstore = '0;
        mem[32'h40]  = 32'hAAAA_0000;  mem[32'h44]  = 32'hAAAA_0001;
        mem[32'h240] = 32'hBBBB_0000;  mem[32'h244] = 32'hBBBB_0001;
        mem[32'h88]  = 32'h8888_0000;  mem[32'h8C]  = 32'h8888_0001;
        mem[32'h10]  = 32'h1010_0000;  mem[32'h14]  = 32'h1010_0001;
        mem[32'h08]  = 32'h0800_0000;  mem[32'h0C]  = 32'h0C00_0000;
        mem[32'h28]  = 32'h2800_0000;  mem[32'h2C]  = 32'h2C00_0000;

        repeat (2) @(negedge CLK);
        check("rst_dhit", dcif.dhit, 0);
        check("rst_flushed", dcif.flushed, 0);
        check("rst_dREN", dcif.dREN, 0);
        check("rst_dWEN", dcif.dWEN, 0);
        check("rst_daddr", dcif.daddr, 0);
        check("rst_dstore", dcif.dstore, 0);
        check("rst_dmemload", dcif.dmemload, 0);
        @(posedge CLK);
        #2 nRST = 1'b1;

        exp_rd.push_back(32'h40);  exp_rd.push_back(32'h44);
        exp_load.push_back(32'hAAAA_0000);
        req(1, 0, 32'h40, 0, nc);
        check("cold_miss_lat", nc, 4);

        r0 = n_rd;  w0 = n_wr;
        exp_load.push_back(32'hAAAA_0001);
        req(1, 0, 32'h44, 0, nc);
        check("hit_lat", nc, 1);
        check("hit_no_mem", n_rd + n_wr, r0 + w0);

        req(0, 1, 32'h40, 32'hDEAD_BEEF, nc);
        check("store_hit_lat", nc, 1);

        exp_wr.push_back('{32'h40, 32'hDEAD_BEEF});
        exp_wr.push_back('{32'h44, 32'hAAAA_0001});
        exp_rd.push_back(32'h240); exp_rd.push_back(32'h244);
        exp_load.push_back(32'hBBBB_0000);
        req(1, 0, 32'h240, 0, nc);
        check("dirty_miss_lat", nc, 6);

        exp_rd.push_back(32'h40);  exp_rd.push_back(32'h44);
        exp_load.push_back(32'hDEAD_BEEF);
        req(1, 0, 32'h40, 0, nc);
        check("clean_evict_lat", nc, 4);

        req(1, 1, 32'h40, 32'h1234_5678, nc);
        check("ren_wen_lat", nc, 1);
        exp_load.push_back(32'h1234_5678);
        req(1, 0, 32'h40, 0, nc);
        check("ren_wen_readback_lat", nc, 1);

        wait_cyc = 5;
        exp_rd.push_back(32'h88);  exp_rd.push_back(32'h8C);
        exp_load.push_back(32'h8888_0000);
        req(1, 0, 32'h88, 0, nc);
        check("dwait_lat", nc, 14);

        wait_cyc = 3;
        exp_rd.push_back(32'h10);
        @(posedge CLK);
        #2;
        dcif.dmemREN  = 1'b1;
        dcif.dmemaddr = 32'h10;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge CLK);
            found = dcif.dREN && (dcif.daddr == 32'h14);
        end
        check("reached_fetch1", found, 1);
        #1 nRST = 1'b0;
        #1;
        check("arst_dREN", dcif.dREN, 0);
        check("arst_dWEN", dcif.dWEN, 0);
        check("arst_daddr", dcif.daddr, 0);
        check("arst_dstore", dcif.dstore, 0);
        check("arst_dhit", dcif.dhit, 0);
        check("arst_dmemload", dcif.dmemload, 0);
        dcif.dmemREN = 1'b0;
        @(posedge CLK);
        #2 nRST = 1'b1;
        wait_cyc = 0;

        exp_rd.push_back(32'h10);  exp_rd.push_back(32'h14);
        exp_load.push_back(32'h1010_0000);
        req(1, 0, 32'h10, 0, nc);
        check("post_rst_miss_lat", nc, 4);

        exp_rd.push_back(32'h08);  exp_rd.push_back(32'h0C);
        req(0, 1, 32'h08, 32'hCAFE_0001, nc);
        check("store_miss_lat1", nc, 4);
        exp_rd.push_back(32'h28);  exp_rd.push_back(32'h2C);
        req(0, 1, 32'h2C, 32'hCAFE_0005, nc);
        check("store_miss_lat5", nc, 4);

        exp_wr.push_back('{32'h08, 32'hCAFE_0001});
        exp_wr.push_back('{32'h0C, 32'h0C00_0000});
        exp_wr.push_back('{32'h28, 32'h2800_0000});
        exp_wr.push_back('{32'h2C, 32'hCAFE_0005});
`ifdef DCACHE_HITCOUNT_EN
        exp_wr.push_back('{32'h3100, 32'd3});
`endif
        w0 = n_wr;
        @(posedge CLK);
        #2 dcif.halt = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge CLK);
            found = dcif.flushed;
        end
        check("flush_done", found, 1);
`ifdef DCACHE_HITCOUNT_EN
        check("flush_writes", n_wr - w0, 5);
`else
        check("flush_writes", n_wr - w0, 4);
`endif

        dcif.halt     = 1'b0;
        dcif.dmemREN  = 1'b1;
        dcif.dmemaddr = 32'h08;
        repeat (3) begin
            @(negedge CLK);
            check("flushed_sticky", dcif.flushed, 1);
            check("done_no_hit", dcif.dhit, 0);
            check("done_no_mem", dcif.dREN | dcif.dWEN, 0);
        end
        dcif.dmemREN = 1'b0;

        check("load_q_empty", exp_load.size(), 0);
        check("rd_q_empty", exp_rd.size(), 0);
        check("wr_q_empty", exp_wr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
